// File: rtl/unpacker_flex_if.sv
// ---------------------------------------------------------------------------
// unpacker_flex_if
// Stream bundle for unpacker_flex: packed-word input handshake plus
// element output handshake.
//   packed_i   : packed input word (PackedWidth)
//   count_i    : valid elements in word minus one (CountWidth)
//   last_i     : word ends a frame
//   valid_i    : input valid          ready_o : input ready
//   unpacked_o : output element       last_o  : final element of a last_i word
//   valid_o    : output valid         ready_i : output ready
//   done_o     : final element of a word moved into the output stage
// slave  = unpacker side, master = source/sink side.
// ---------------------------------------------------------------------------
interface unpacker_flex_if #(
    parameter int unsigned UnpackedWidth = 2,
    parameter int unsigned PackedNum     = 4
);
    localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
    localparam int unsigned CountWidth  = $clog2(PackedNum);

    logic [PackedWidth-1:0]   packed_i;
    logic [CountWidth-1:0]    count_i;
    logic                     last_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [UnpackedWidth-1:0] unpacked_o;
    logic                     last_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     done_o;

    modport slave (
        input  packed_i, count_i, last_i, valid_i, ready_i,
        output ready_o, unpacked_o, last_o, valid_o, done_o
    );

    modport master (
        output packed_i, count_i, last_i, valid_i, ready_i,
        input  ready_o, unpacked_o, last_o, valid_o, done_o
    );
endinterface

// File: rtl/unpacker_flex.sv
// ---------------------------------------------------------------------------
// unpacker_flex
// Splits each accepted packed word into 1..PackedNum elements (count_i+1,
// clamped), emitted one per clock through a registered valid/ready stage.
// Element order selectable by MsbFirst; last_i is tagged onto the final
// element of the word. Back-to-back words run without a bubble.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : unpacker_flex_if.slave (input word handshake, element output
//           handshake, done_o pulse)
// ---------------------------------------------------------------------------
module unpacker_flex #(
    parameter int unsigned UnpackedWidth = 2,
    parameter int unsigned PackedNum     = 4,
    parameter bit          MsbFirst      = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    unpacker_flex_if.slave  bus
);
    localparam int unsigned PackedWidth = UnpackedWidth * PackedNum;
    localparam int unsigned CountWidth  = $clog2(PackedNum);
    localparam logic [CountWidth-1:0] LP_MAX = CountWidth'(PackedNum - 1);

    typedef enum logic {
        ST_IDLE,
        ST_UNPACK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PackedWidth-1:0]   r_word;
    logic                     r_last;
    logic [CountWidth-1:0]    r_cnt;
    logic [CountWidth-1:0]    r_idx;
    logic [UnpackedWidth-1:0] r_out_data;
    logic                     r_out_last;
    logic                     r_out_valid;

    logic                     w_load;
    logic                     w_produce;
    logic                     w_final;
    logic                     w_ready;
    logic                     w_in_fire;
    logic [CountWidth-1:0]    w_sel;
    logic [UnpackedWidth-1:0] w_elem;
    logic [UnpackedWidth-1:0] w_elems [PackedNum];

    // Element slices of the held word, indexed by element position.
    for (genvar g = 0; g < PackedNum; g++) begin : g_elem
        assign w_elems[g] = r_word[g*UnpackedWidth +: UnpackedWidth];
    end

    // idx never exceeds cnt <= PackedNum-1, so the mirrored index stays in range.
    assign w_sel  = MsbFirst ? (LP_MAX - r_idx) : r_idx;
    assign w_elem = w_elems[w_sel];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // Output stage can take a new element when empty or being drained.
        w_load      = !r_out_valid || bus.ready_i;
        w_produce   = (r_state == ST_UNPACK) && w_load;
        w_final     = w_produce && (r_idx == r_cnt);
        w_ready     = (r_state == ST_IDLE) || w_final;
        w_in_fire   = bus.valid_i && w_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (w_final) begin
                    w_state_nxt = w_in_fire ? ST_UNPACK : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_word      <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_word <= bus.packed_i;
                r_last <= bus.last_i;
                r_cnt  <= (bus.count_i >= LP_MAX) ? LP_MAX : bus.count_i;
                r_idx  <= '0;
            end else if (w_produce && !w_final) begin
                r_idx  <= r_idx + 1'b1;
            end

            if (w_produce) begin
                r_out_data  <= w_elem;
                r_out_last  <= r_last && w_final;
                r_out_valid <= 1'b1;
            end else if (bus.ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.ready_o    = w_ready;
    assign bus.done_o     = w_final;
    assign bus.unpacked_o = r_out_data;
    assign bus.last_o     = r_out_last;
    assign bus.valid_o    = r_out_valid;

endmodule

// File: tb/tb_unpacker_flex.sv
// ---------------------------------------------------------------------------
// tb_unpacker_flex
// Self-checking bench for unpacker_flex. Two instances (LSB-first and
// MSB-first) receive identical stimulus; a reference model expands each
// accepted word into its expected element/last sequence, and a negedge
// monitor compares every output transfer and the hold-while-stalled rule.
// ---------------------------------------------------------------------------
module tb_unpacker_flex;
    localparam int unsigned W = 2;
    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv_packed = '0;
    logic [1:0] drv_count  = '0;
    logic       drv_last   = 1'b0;
    logic       drv_valid  = 1'b0;
    logic       drv_ready  = 1'b1;

    int errors = 0;
    int checks = 0;
    bit sb_en  = 1'b0;
    int words_in = 0;
    int done_cnt = 0;

    int qd0[$], ql0[$], qd1[$], ql1[$];

    always #5 clk = ~clk;

    unpacker_flex_if #(.UnpackedWidth(W), .PackedNum(N)) if0 ();
    unpacker_flex_if #(.UnpackedWidth(W), .PackedNum(N)) if1 ();

    assign if0.packed_i = drv_packed;
    assign if0.count_i  = drv_count;
    assign if0.last_i   = drv_last;
    assign if0.valid_i  = drv_valid;
    assign if0.ready_i  = drv_ready;
    assign if1.packed_i = drv_packed;
    assign if1.count_i  = drv_count;
    assign if1.last_i   = drv_last;
    assign if1.valid_i  = drv_valid;
    assign if1.ready_i  = drv_ready;

    unpacker_flex #(.UnpackedWidth(W), .PackedNum(N), .MsbFirst(1'b0)) u_lsb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0)
    );

    unpacker_flex #(.UnpackedWidth(W), .PackedNum(N), .MsbFirst(1'b1)) u_msb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1)
    );

    // Reference: a word yields min(count,N-1)+1 elements; element k sits at
    // position k (LSB-first) or N-1-k (MSB-first); last only on the final one.
    function automatic void model_push(int unsigned word, int unsigned cnt, int unsigned lst);
        int unsigned n;
        n = ((cnt >= N - 1) ? (N - 1) : cnt) + 1;
        for (int unsigned k = 0; k < n; k++) begin
            qd0.push_back(int'((word >> (k * W)) % (1 << W)));
            qd1.push_back(int'((word >> ((N - 1 - k) * W)) % (1 << W)));
            ql0.push_back((lst != 0 && k == n - 1) ? 1 : 0);
            ql1.push_back((lst != 0 && k == n - 1) ? 1 : 0);
        end
    endfunction

    // Scoreboard monitor, sampling on the inactive edge.
    initial begin : monitor
        bit p_v0, p_v1, p_r, p_l0, p_l1;
        logic [1:0] p_d0, p_d1;
        int ed, el;
        p_v0 = 0; p_v1 = 0; p_r = 0; p_l0 = 0; p_l1 = 0; p_d0 = '0; p_d1 = '0;
        forever begin
            @(negedge clk);
            if (rst || !sb_en) begin
                p_v0 = 0; p_v1 = 0; p_r = 1;
            end else begin
                if (drv_valid && if0.ready_o) begin
                    model_push(drv_packed, drv_count, drv_last);
                    words_in++;
                end
                if (if0.done_o) done_cnt++;
                if (p_v0 && !p_r) begin
                    checks++;
                    if (if0.valid_o !== 1'b1 || if0.unpacked_o !== p_d0 || if0.last_o !== p_l0) begin
                        errors++;
                        $display("FAIL stall_hold_lsb: got v=%b d=%0d l=%b, need v=1 d=%0d l=%b",
                                 if0.valid_o, if0.unpacked_o, if0.last_o, p_d0, p_l0);
                    end
                end
                if (p_v1 && !p_r) begin
                    checks++;
                    if (if1.valid_o !== 1'b1 || if1.unpacked_o !== p_d1 || if1.last_o !== p_l1) begin
                        errors++;
                        $display("FAIL stall_hold_msb: got v=%b d=%0d l=%b, need v=1 d=%0d l=%b",
                                 if1.valid_o, if1.unpacked_o, if1.last_o, p_d1, p_l1);
                    end
                end
                if (if0.valid_o && drv_ready) begin
                    checks++;
                    if (qd0.size() == 0) begin
                        errors++;
                        $display("FAIL sb_lsb_extra: got d=%0d with no element expected", if0.unpacked_o);
                    end else begin
                        ed = qd0.pop_front();
                        el = ql0.pop_front();
                        if (if0.unpacked_o !== 2'(ed) || if0.last_o !== 1'(el)) begin
                            errors++;
                            $display("FAIL sb_lsb: got d=%0d l=%b, need d=%0d l=%0d",
                                     if0.unpacked_o, if0.last_o, ed, el);
                        end
                    end
                end
                if (if1.valid_o && drv_ready) begin
                    checks++;
                    if (qd1.size() == 0) begin
                        errors++;
                        $display("FAIL sb_msb_extra: got d=%0d with no element expected", if1.unpacked_o);
                    end else begin
                        ed = qd1.pop_front();
                        el = ql1.pop_front();
                        if (if1.unpacked_o !== 2'(ed) || if1.last_o !== 1'(el)) begin
                            errors++;
                            $display("FAIL sb_msb: got d=%0d l=%b, need d=%0d l=%0d",
                                     if1.unpacked_o, if1.last_o, ed, el);
                        end
                    end
                end
                p_v0 = if0.valid_o; p_d0 = if0.unpacked_o; p_l0 = if0.last_o;
                p_v1 = if1.valid_o; p_d1 = if1.unpacked_o; p_l1 = if1.last_o;
                p_r  = drv_ready;
            end
        end
    end

    task automatic test_reset;
        #3;
        checks++;
        if (if0.valid_o !== 1'b0 || if0.unpacked_o !== 2'd0 || if0.last_o !== 1'b0 ||
            if0.done_o !== 1'b0 || if0.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_lsb: got v=%b d=%0d l=%b done=%b rdy=%b, need 0 0 0 0 1",
                     if0.valid_o, if0.unpacked_o, if0.last_o, if0.done_o, if0.ready_o);
        end
        checks++;
        if (if1.valid_o !== 1'b0 || if1.unpacked_o !== 2'd0 || if1.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_msb: got v=%b d=%0d rdy=%b, need 0 0 1",
                     if1.valid_o, if1.unpacked_o, if1.ready_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_single_full;
        int d0c;
        d0c = done_cnt;
        @(posedge clk); #1;
        drv_packed = 8'hE4; drv_count = 2'd3; drv_last = 1'b0; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        checks++;
        if (if0.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_e0: got valid=%b, need 0", if0.valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (if0.valid_o !== 1'b1 || if0.unpacked_o !== 2'(k) || if0.last_o !== 1'b0) begin
                errors++;
                $display("FAIL full_lsb[%0d]: got v=%b d=%0d l=%b, need v=1 d=%0d l=0",
                         k, if0.valid_o, if0.unpacked_o, if0.last_o, k);
            end
            checks++;
            if (if1.valid_o !== 1'b1 || if1.unpacked_o !== 2'(3 - k) || if1.last_o !== 1'b0) begin
                errors++;
                $display("FAIL full_msb[%0d]: got v=%b d=%0d l=%b, need v=1 d=%0d l=0",
                         k, if1.valid_o, if1.unpacked_o, if1.last_o, 3 - k);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b0 || done_cnt - d0c !== 1) begin
            errors++;
            $display("FAIL full_end: got valid=%b dones=%0d, need valid=0 dones=1",
                     if0.valid_o, done_cnt - d0c);
        end
    endtask

    task automatic test_partial_last;
        @(posedge clk); #1;
        drv_packed = 8'hE4; drv_count = 2'd1; drv_last = 1'b1; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        checks++;
        if (if0.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL partial_busy: got ready_o=%b, need 0", if0.ready_o);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b1 || if0.unpacked_o !== 2'd0 || if0.last_o !== 1'b0 ||
            if0.ready_o !== 1'b1 || if0.done_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_e0: got v=%b d=%0d l=%b rdy=%b done=%b, need 1 0 0 1 1",
                     if0.valid_o, if0.unpacked_o, if0.last_o, if0.ready_o, if0.done_o);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b1 || if0.unpacked_o !== 2'd1 || if0.last_o !== 1'b1 || if0.done_o !== 1'b0) begin
            errors++;
            $display("FAIL partial_e1_lsb: got v=%b d=%0d l=%b done=%b, need 1 1 1 0",
                     if0.valid_o, if0.unpacked_o, if0.last_o, if0.done_o);
        end
        checks++;
        if (if1.unpacked_o !== 2'd2 || if1.last_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_e1_msb: got d=%0d l=%b, need d=2 l=1", if1.unpacked_o, if1.last_o);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL partial_end: got valid=%b, need 0", if0.valid_o);
        end
    endtask

    task automatic test_back_to_back;
        int exp0 [8];
        int exp1 [8];
        int d0c;
        exp0 = '{3, 2, 1, 0, 0, 1, 2, 3};
        exp1 = '{0, 1, 2, 3, 3, 2, 1, 0};
        d0c = done_cnt;
        @(posedge clk); #1;
        drv_packed = 8'h1B; drv_count = 2'd3; drv_last = 1'b0; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_packed = 8'hE4;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) drv_valid = 1'b0;
            checks++;
            if (if0.valid_o !== 1'b1 || if0.unpacked_o !== 2'(exp0[k])) begin
                errors++;
                $display("FAIL b2b_lsb[%0d]: got v=%b d=%0d, need v=1 d=%0d",
                         k, if0.valid_o, if0.unpacked_o, exp0[k]);
            end
            checks++;
            if (if1.valid_o !== 1'b1 || if1.unpacked_o !== 2'(exp1[k])) begin
                errors++;
                $display("FAIL b2b_msb[%0d]: got v=%b d=%0d, need v=1 d=%0d",
                         k, if1.valid_o, if1.unpacked_o, exp1[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b0 || done_cnt - d0c !== 2) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b dones=%0d, need valid=0 dones=2",
                     if0.valid_o, done_cnt - d0c);
        end
    endtask

    task automatic test_random;
        int sent, cycles, w0, d0c;
        bit fired;
        sent = 0; cycles = 0; fired = 0;
        w0 = words_in; d0c = done_cnt;
        while (sent < 1000 && cycles < 20000) begin
            @(posedge clk); #1;
            cycles++;
            if (drv_valid && fired) begin
                drv_valid = 1'b0;
                sent++;
            end
            if (!drv_valid && sent < 1000 && ($urandom % 4) != 0) begin
                drv_packed = 8'($urandom);
                drv_count  = 2'($urandom);
                drv_last   = (($urandom % 3) == 0);
                drv_valid  = 1'b1;
            end
            drv_ready = (($urandom % 3) != 0);
            @(negedge clk);
            fired = drv_valid && if0.ready_o;
        end
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("FAIL random_timeout: got %0d words accepted, need 1000", sent);
        end
        @(posedge clk); #1;
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (qd0.size() != 0 || qd1.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d/%0d elements outstanding, need 0/0", qd0.size(), qd1.size());
        end
        checks++;
        if (words_in - w0 != 1000 || done_cnt - d0c != 1000) begin
            errors++;
            $display("FAIL random_counts: got words=%0d dones=%0d, need 1000 1000",
                     words_in - w0, done_cnt - d0c);
        end
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        drv_packed = 8'hE4; drv_count = 2'd3; drv_last = 1'b1; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        sb_en = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if (if0.valid_o !== 1'b0 || if0.unpacked_o !== 2'd0 || if0.last_o !== 1'b0 ||
            if0.ready_o !== 1'b1 || if0.done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_lsb: got v=%b d=%0d l=%b rdy=%b done=%b, need 0 0 0 1 0",
                     if0.valid_o, if0.unpacked_o, if0.last_o, if0.ready_o, if0.done_o);
        end
        checks++;
        if (if1.valid_o !== 1'b0 || if1.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_msb: got v=%b rdy=%b, need 0 1", if1.valid_o, if1.ready_o);
        end
        qd0.delete(); ql0.delete(); qd1.delete(); ql1.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b0 || if0.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_idle: got v=%b rdy=%b, need 0 1", if0.valid_o, if0.ready_o);
        end
        drv_packed = 8'h1B; drv_count = 2'd3; drv_last = 1'b0; drv_valid = 1'b1;
        sb_en = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if0.valid_o !== 1'b1 || if0.unpacked_o !== 2'd3 || if1.unpacked_o !== 2'd0) begin
            errors++;
            $display("FAIL post_rst_first: got v=%b lsb=%0d msb=%0d, need v=1 lsb=3 msb=0",
                     if0.valid_o, if0.unpacked_o, if1.unpacked_o);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (qd0.size() != 0 || if0.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_drain: got %0d outstanding valid=%b, need 0 0", qd0.size(), if0.valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_full();
        test_partial_last();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
